// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem req/ack, decode output register, redirect squash, halt
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imemReq,
  output logic [15:0] imemAddr,
  input  logic        imemAck,
  input  logic [15:0] imemData,
  output logic [15:0] instr,
  output logic        instrValid,
  output logic [15:0] pcOut,
  input  logic        stall,
  input  logic        hlt,
  input  logic        redirect,
  input  logic [15:0] redirectPc,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  state_t      state, state_nxt;
  logic [15:0] fetch_pc, fetch_pc_nxt;
  logic [15:0] pend_pc, pend_pc_nxt;
  logic        squash, squash_nxt;
  logic [15:0] instr_nxt, pc_out_nxt;

  // The memory address always tracks the fetch PC register; it only moves when the
  // outstanding request has been acked, so it stays stable while imemReq is high.
  assign imemAddr = fetch_pc;

  // State, PC and output registers; the status flags are registered copies of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      pend_pc    <= 16'h0000;
      squash     <= 1'b0;
      instr      <= 16'h0000;
      pcOut      <= 16'h0000;
      imemReq    <= 1'b0;
      instrValid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      pend_pc    <= pend_pc_nxt;
      squash     <= squash_nxt;
      instr      <= instr_nxt;
      pcOut      <= pc_out_nxt;
      imemReq    <= (state_nxt == FETCH);
      instrValid <= (state_nxt == HOLD);
      halted     <= (state_nxt == HALT);
    end
  end

  // Next-state logic: fetch handshake, squash of a redirected in-flight fetch, decode hand-off and halt.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    pend_pc_nxt  = pend_pc;
    squash_nxt   = squash;
    instr_nxt    = instr;
    pc_out_nxt   = pcOut;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
        if (redirect) fetch_pc_nxt = redirectPc;
      end
      FETCH: begin
        if (imemAck) begin
          if (squash || redirect) begin
            // Wrong-path data: drop it and refetch from the newest target.
            fetch_pc_nxt = redirect ? redirectPc : pend_pc;
            squash_nxt   = 1'b0;
          end else begin
            instr_nxt    = imemData;
            pc_out_nxt   = fetch_pc;
            fetch_pc_nxt = fetch_pc + 16'd1;
            state_nxt    = HOLD;
          end
        end else if (redirect) begin
          // The address cannot change under an outstanding request; remember the target.
          squash_nxt  = 1'b1;
          pend_pc_nxt = redirectPc;
        end
      end
      HOLD: begin
        // A redirect comes from an older instruction, so it beats a (wrong-path) HLT.
        if (redirect) begin
          fetch_pc_nxt = redirectPc;
          state_nxt    = FETCH;
        end else if (!stall) begin
          state_nxt = hlt ? HALT : FETCH;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with default reset PC
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc_out;
  logic        stall;
  logic        hlt;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imemReq(imem_req), .imemAddr(imem_addr), .imemAck(imem_ack), .imemData(imem_data),
    .instr(instr), .instrValid(instr_valid), .pcOut(pc_out),
    .stall(stall), .hlt(hlt), .redirect(redirect), .redirectPc(redirect_pc),
    .halted(halted)
  );

  // DUT with reset PC at the top of the address space
  logic        rst2_n;
  logic        req2;
  logic [15:0] addr2;
  logic        ack2;
  logic [15:0] data2;
  logic [15:0] instr2;
  logic        valid2;
  logic [15:0] pc2;
  logic        stall2;
  logic        hlt2;
  logic        redir2;
  logic [15:0] rpc2;
  logic        halted2;

  fetch_unit #(.RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .imemReq(req2), .imemAddr(addr2), .imemAck(ack2), .imemData(data2),
    .instr(instr2), .instrValid(valid2), .pcOut(pc2),
    .stall(stall2), .hlt(hlt2), .redirect(redir2), .redirectPc(rpc2),
    .halted(halted2)
  );

  typedef struct {
    logic        ack;
    logic [15:0] data;
    logic        stall;
    logic        hlt;
    logic        redir;
    logic [15:0] rpc;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        halted;
  } vec_t;

  vec_t vecs[23];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic a, logic [15:0] d, logic s, logic h, logic r, logic [15:0] rp,
                              logic q, logic [15:0] ad, logic v, logic [15:0] in, logic [15:0] p,
                              logic hd);
    vec_t t;
    t.ack = a; t.data = d; t.stall = s; t.hlt = h; t.redir = r; t.rpc = rp;
    t.req = q; t.addr = ad; t.valid = v; t.instr = in; t.pc = p; t.halted = hd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = 16'h0000; stall = 1'b0; hlt = 1'b0;
    redirect = 1'b0; redirect_pc = 16'h0000;
    rst2_n = 1'b0; ack2 = 1'b0; data2 = 16'h0000; stall2 = 1'b0; hlt2 = 1'b0;
    redir2 = 1'b0; rpc2 = 16'h0000;

    //              ack data     stl hlt rdr rpc       req addr     vld instr    pc       hltd
    vecs[0]  = mk(0, 16'h0000, 0, 0, 0, 16'h0000,  1, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    vecs[1]  = mk(0, 16'h0000, 0, 0, 0, 16'h0000,  1, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    vecs[2]  = mk(1, 16'h1234, 0, 0, 0, 16'h0000,  0, 16'h0001, 1, 16'h1234, 16'h0000, 0);
    vecs[3]  = mk(0, 16'h0000, 0, 0, 0, 16'h0000,  1, 16'h0001, 0, 16'h1234, 16'h0000, 0);
    vecs[4]  = mk(0, 16'h0000, 0, 0, 0, 16'h0000,  1, 16'h0001, 0, 16'h1234, 16'h0000, 0);
    vecs[5]  = mk(1, 16'h2345, 0, 0, 0, 16'h0000,  0, 16'h0002, 1, 16'h2345, 16'h0001, 0);
    vecs[6]  = mk(0, 16'h0000, 1, 0, 0, 16'h0000,  0, 16'h0002, 1, 16'h2345, 16'h0001, 0);
    vecs[7]  = mk(0, 16'h0000, 1, 1, 0, 16'h0000,  0, 16'h0002, 1, 16'h2345, 16'h0001, 0);
    vecs[8]  = mk(0, 16'h0000, 0, 0, 0, 16'h0000,  1, 16'h0002, 0, 16'h2345, 16'h0001, 0);
    vecs[9]  = mk(1, 16'hA123, 0, 0, 0, 16'h0000,  0, 16'h0003, 1, 16'hA123, 16'h0002, 0);
    vecs[10] = mk(0, 16'h0000, 0, 0, 0, 16'h0000,  1, 16'h0003, 0, 16'hA123, 16'h0002, 0);
    vecs[11] = mk(0, 16'h0000, 0, 0, 1, 16'h0040,  1, 16'h0003, 0, 16'hA123, 16'h0002, 0);
    vecs[12] = mk(0, 16'h0000, 0, 0, 1, 16'h0080,  1, 16'h0003, 0, 16'hA123, 16'h0002, 0);
    vecs[13] = mk(1, 16'hBEEF, 0, 0, 0, 16'h0000,  1, 16'h0080, 0, 16'hA123, 16'h0002, 0);
    vecs[14] = mk(1, 16'h5555, 0, 0, 1, 16'h0100,  1, 16'h0100, 0, 16'hA123, 16'h0002, 0);
    vecs[15] = mk(1, 16'h6666, 0, 0, 0, 16'h0000,  0, 16'h0101, 1, 16'h6666, 16'h0100, 0);
    vecs[16] = mk(0, 16'h0000, 0, 1, 1, 16'h0200,  1, 16'h0200, 0, 16'h6666, 16'h0100, 0);
    vecs[17] = mk(1, 16'h0000, 0, 0, 0, 16'h0000,  0, 16'h0201, 1, 16'h0000, 16'h0200, 0);
    vecs[18] = mk(0, 16'h0000, 1, 1, 0, 16'h0000,  0, 16'h0201, 1, 16'h0000, 16'h0200, 0);
    vecs[19] = mk(0, 16'h0000, 1, 1, 0, 16'h0000,  0, 16'h0201, 1, 16'h0000, 16'h0200, 0);
    vecs[20] = mk(0, 16'h0000, 0, 1, 0, 16'h0000,  0, 16'h0201, 0, 16'h0000, 16'h0200, 1);
    vecs[21] = mk(0, 16'h0000, 0, 0, 1, 16'h0300,  0, 16'h0201, 0, 16'h0000, 16'h0200, 1);
    vecs[22] = mk(1, 16'h1111, 0, 0, 0, 16'h0000,  0, 16'h0201, 0, 16'h0000, 16'h0200, 1);

    // Reset values of both instances
    step();
    chk("rst.req",    imem_req,    1'b0);
    chk("rst.addr",   imem_addr,   16'h0000);
    chk("rst.valid",  instr_valid, 1'b0);
    chk("rst.instr",  instr,       16'h0000);
    chk("rst.pc",     pc_out,      16'h0000);
    chk("rst.halted", halted,      1'b0);
    chk("rst2.addr",  addr2,       16'hFFFF);
    chk("rst2.req",   req2,        1'b0);

    rst_n = 1'b1;
    for (int i = 0; i < 23; i++) begin
      imem_ack = vecs[i].ack; imem_data = vecs[i].data; stall = vecs[i].stall;
      hlt = vecs[i].hlt; redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
      step();
      chk($sformatf("v%0d.req", i),    imem_req,    vecs[i].req);
      chk($sformatf("v%0d.addr", i),   imem_addr,   vecs[i].addr);
      chk($sformatf("v%0d.valid", i),  instr_valid, vecs[i].valid);
      chk($sformatf("v%0d.instr", i),  instr,       vecs[i].instr);
      chk($sformatf("v%0d.pc", i),     pc_out,      vecs[i].pc);
      chk($sformatf("v%0d.halted", i), halted,      vecs[i].halted);
    end

    // Halt is permanent: redirects, acks and hlt are all ignored
    for (int i = 0; i < 20; i++) begin
      redirect = (i % 3 == 0); redirect_pc = 16'($urandom_range(0, 65535));
      imem_ack = (i % 2 == 0); imem_data = 16'($urandom_range(0, 65535));
      hlt = 1'b1; stall = 1'b0;
      step();
      chk($sformatf("halt%0d.req", i),    imem_req,    1'b0);
      chk($sformatf("halt%0d.valid", i),  instr_valid, 1'b0);
      chk($sformatf("halt%0d.halted", i), halted,      1'b1);
    end
    redirect = 1'b0; imem_ack = 1'b0; hlt = 1'b0;

    // Reset clears halt; a redirect in IDLE retargets the first fetch
    rst_n = 1'b0;
    #1;
    chk("rehalt.halted", halted, 1'b0);
    chk("rehalt.addr", imem_addr, 16'h0000);
    rst_n = 1'b1;
    redirect = 1'b1; redirect_pc = 16'h0777;
    step();
    redirect = 1'b0;
    chk("idle_redir.req", imem_req, 1'b1);
    chk("idle_redir.addr", imem_addr, 16'h0777);
    imem_ack = 1'b1; imem_data = 16'hABCD;
    step();
    imem_ack = 1'b0;
    chk("idle_redir.valid", instr_valid, 1'b1);
    chk("idle_redir.instr", instr, 16'hABCD);
    chk("idle_redir.pc", pc_out, 16'h0777);
    chk("idle_redir.next", imem_addr, 16'h0778);

    // RESET_PC = FFFF: wrap and asynchronous reset mid-fetch
    rst2_n = 1'b1;
    ack2 = 1'b1; data2 = 16'h9999;
    step();
    chk("w.late_ack.valid", valid2, 1'b0);
    chk("w.req", req2, 1'b1);
    chk("w.addr", addr2, 16'hFFFF);
    ack2 = 1'b1; data2 = 16'h7777;
    step();
    ack2 = 1'b0;
    chk("w.valid", valid2, 1'b1);
    chk("w.pc", pc2, 16'hFFFF);
    chk("w.instr", instr2, 16'h7777);
    chk("w.wrap", addr2, 16'h0000);
    step();
    chk("w.req2", req2, 1'b1);
    chk("w.addr2", addr2, 16'h0000);
    #2;
    rst2_n = 1'b0;
    #1;
    chk("w.async.req", req2, 1'b0);
    chk("w.async.addr", addr2, 16'hFFFF);
    chk("w.async.valid", valid2, 1'b0);
    #1;
    rst2_n = 1'b1;
    step();
    chk("w.restart.req", req2, 1'b1);
    chk("w.restart.addr", addr2, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage. It is the upstream producer of the 16-bit instruction word that the control decoder consumes, and the consumer of that decoder's hlt output and the pipeline's redirect.
- Keeps the word-addressed PC.
- Runs a req/ack handshake with instruction memory.
- Holds one instruction in an output register for decode.
- Handles branch/jump redirects, including squashing an in-flight fetch, and enters a permanent halt on HLT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset (word address).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
imemReq  output  1  fetch request; held high until imemAck.
imemAddr  output  16  fetch word address; stable while imemReq high.
imemAck  input  1  single-cycle pulse; imemData valid in the same cycle.
imemData  input  16  instruction word from memory.
instr  output  16  instruction presented to decode/control.
instrValid  output  1  instr/pcOut hold a valid, unsquashed instruction.
pcOut  output  16  address of the presented instr.
stall  input  1  decode cannot accept this cycle. Accept = instrValid & !stall.
hlt  input  1  control's HLT decode of the presented instr; sampled only on accept.
redirect  input  1  single-cycle pulse from branch/jump resolution; the fetch path is wrong.
redirectPc  input  16  target word address, valid with redirect.
halted  output  1  processor halted; sticky until reset.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=IDLE, fetchPc=RESET_PC, squash=0, pendPc=0.
  - imemReq=0, imemAddr=RESET_PC, instr=16'h0000, pcOut=16'h0000, instrValid=0, halted=0.
- Reset mid-fetch abandons the request. Memory must tolerate the dropped req. A late ack after reset is ignored because state is IDLE.
- States: IDLE, FETCH, HOLD, HALT. All outputs are registered. imemAddr=fetchPc at all times.
- IDLE:
  - imemReq=0; next state FETCH.
  - redirect in IDLE: fetchPc<=redirectPc.
- FETCH: imemReq=1.
  - No ack + redirect: squash<=1, pendPc<=redirectPc. If several redirects arrive, the latest wins. imemAddr is unchanged (protocol rule).
  - Ack with squash=1 or redirect in the same cycle: discard imemData. fetchPc<=(redirect ? redirectPc : pendPc), squash<=0. Stay FETCH. imemReq stays high; the new address appears the next cycle.
  - Ack, no squash: instr<=imemData, pcOut<=fetchPc, instrValid<=1, fetchPc<=fetchPc+1 (16-bit wrap, FFFF->0000). Go to HOLD; imemReq<=0.
- HOLD: imemReq=0, instrValid=1. Priority is redirect > accept.
  - redirect (regardless of stall or hlt): instrValid<=0, fetchPc<=redirectPc. Go to FETCH.
  - Accept with hlt=1: instrValid<=0, halted<=1. Go to HALT.
  - Accept with hlt=0: instrValid<=0. Go to FETCH.
  - stall=1: hold instr/pcOut/instrValid unchanged. hlt is ignored until accept.
- HALT: imemReq=0, instrValid=0, halted=1. All inputs are ignored; only rst_n exits.
- Latency:
  - Ack cycle t → instrValid high at t+1.
  - Accept at t+1 → imemReq high at t+2.
  - Peak throughput is one instruction per 3 cycles with a 1-cycle memory.
- A redirect wins over hlt because the redirect comes from an older instruction, which makes the HLT wrong-path.

Test Plan:
- Reset release, memory acks every request 1 cycle after req with data 16'h1234, 16'h2345..., stall=0 → imemAddr 0000, 0001, 0002 in order; pcOut matches; instrValid pulses once per fetch; first instrValid 3 cycles after rst_n rises.
- stall=1 for 5 cycles while instr=16'hA123 valid → instr/pcOut stable, imemReq=0 throughout; next fetch is issued the cycle after stall drops.
- redirect to 16'h0040 while a FETCH of 0005 is outstanding, ack arrives 3 cycles later with 16'hBEEF → 16'hBEEF never shows with instrValid; next imemAddr=0040.
- Two redirects (0040, then 0080) during one outstanding fetch → after ack, imemAddr=0080.
- Presented instr 16'h0000 with hlt=1 and stall=1 for 2 cycles, then stall=0 → halted rises on the accept edge; imemReq and instrValid stay 0 for 20 further cycles even with redirect pulses. Also, hlt=1 with redirect in the same cycle → no halt; imemAddr=redirectPc.
- RESET_PC=16'hFFFF → fetch FFFF then 0000 (wrap). Asserting rst_n=0 mid-fetch → imemReq drops immediately (asynchronously) and fetch restarts at FFFF.
